// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control for a five-stage in-order core.
//   - operand forwarding selects for the execute-stage ALU inputs
//   - load-use / RAW stall and bubble insertion
//   - branch flush
//   - data-memory wait stall with a sticky timeout flag
//   - saturating count of stalled fetch cycles
// Build option: define HAZARD_FORWARDING_EN to enable forwarding. Without it,
// the forward selects are tied to 00. Any RAW dependency on E/M/W then stalls decode.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             regwrite_en_E,
    input  logic             regwrite_en_M,
    input  logic             regwrite_en_W,
    input  logic [1:0]       wb_src_E,
    input  logic             pc_src_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       forward_A_E,
    output logic [1:0]       forward_B_E,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // The wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // A producer at register rd with write enable we feeds a consumer reading rs.
    // x0 is never a real dependency.
    function automatic logic raw_match(input logic [4:0] rs, input logic [4:0] rd,
                                       input logic we);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    // Operand select: the memory stage holds the newer value, so it wins over writeback.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        logic [1:0] sel;
        if (raw_match(rs, rd_m, we_m)) begin
            sel = 2'b10;
        end else if (raw_match(rs, rd_w, we_w)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               mw_s;
    logic               lu_s;
    logic [1:0]         fwd_a_s;
    logic [1:0]         fwd_b_s;

`ifdef HAZARD_FORWARDING_EN
    // Forwarding build: only a load in execute forces a stall. Every other hazard is bypassed.
    always_comb begin
        fwd_a_s = fwd_sel(Rs1_E, RD_M, regwrite_en_M, RD_W, regwrite_en_W);
        fwd_b_s = fwd_sel(Rs2_E, RD_M, regwrite_en_M, RD_W, regwrite_en_W);
        lu_s    = (wb_src_E == 2'b01) &&
                  (raw_match(Rs1_D, RD_E, regwrite_en_E) ||
                   raw_match(Rs2_D, RD_E, regwrite_en_E));
    end
`else
    // These ports only matter for forwarding; fold them so they are not left dangling.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{Rs1_E, Rs2_E, wb_src_E};

    // Non-forwarding build: any in-flight producer of a decode operand stalls decode.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        lu_s    = raw_match(Rs1_D, RD_E, regwrite_en_E) ||
                  raw_match(Rs2_D, RD_E, regwrite_en_E) ||
                  raw_match(Rs1_D, RD_M, regwrite_en_M) ||
                  raw_match(Rs2_D, RD_M, regwrite_en_M) ||
                  raw_match(Rs1_D, RD_W, regwrite_en_W) ||
                  raw_match(Rs2_D, RD_W, regwrite_en_W);
    end
`endif

    assign mw_s = dmem_req_M && !dmem_ready;

    // Hazard priority: a memory wait freezes everything, then a branch, then a load-use.
    // Outputs depend only on current inputs, so a ready cycle releases the stalls at once.
    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        stall_M     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_W     = 1'b0;
        forward_A_E = 2'b00;
        forward_B_E = 2'b00;
        if (rst) begin
            stall_F = 1'b0;
        end else begin
            forward_A_E = fwd_a_s;
            forward_B_E = fwd_b_s;
            if (mw_s) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (pc_src_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (lu_s) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end else begin
                stall_F = 1'b0;
            end
        end
    end

    // Next-state logic for the memory-wait FSM, timeout flag and stall counter.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mw_s) begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (!mw_s) begin
                    state_d = ST_RUN;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d   = ST_WAIT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
        if (stall_F && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit (MEM_TIMEOUT=4, CNT_W=4).
// Expectations follow whichever build HAZARD_FORWARDING_EN selects.
module tb_hazard_unit;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
    localparam logic [6:0] CTL_NONE = 7'b0000000;
    localparam logic [6:0] CTL_LU   = 7'b1100010;
    localparam logic [6:0] CTL_BR   = 7'b0000110;
    localparam logic [6:0] CTL_MW   = 7'b1111001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic       regwrite_en_E, regwrite_en_M, regwrite_en_W;
    logic [1:0] wb_src_E;
    logic       pc_src_E, dmem_req_M, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, flush_W;
    logic [1:0] forward_A_E, forward_B_E;
    logic       mem_timeout;
    logic [3:0] stall_cycles;
    logic [6:0] ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .regwrite_en_E(regwrite_en_E), .regwrite_en_M(regwrite_en_M),
        .regwrite_en_W(regwrite_en_W), .wb_src_E(wb_src_E),
        .pc_src_E(pc_src_E), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    task automatic clear_inputs();
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
        RD_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
        regwrite_en_E = 1'b0; regwrite_en_M = 1'b0; regwrite_en_W = 1'b0;
        wb_src_E = 2'b00; pc_src_E = 1'b0; dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        wb_src_E = 2'b01; regwrite_en_E = 1'b1; RD_E = rd;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        dmem_req_M = 1'b1; pc_src_E = 1'b1;
        Rs1_E = 5'd5; RD_M = 5'd5; regwrite_en_M = 1'b1;
        set_load(5'd7); Rs1_D = 5'd7;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE);
        end
        checks++;
        if (forward_A_E !== 2'b00) begin
            errors++; $display("FAIL reset_fwdA: got %b expected 00", forward_A_E);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== 4'd0) begin
            errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        do_reset();
        Rs1_E = 5'd5; RD_M = 5'd5; regwrite_en_M = 1'b1; RD_W = 5'd5; regwrite_en_W = 1'b1;
        #1;
        checks++;
        if (forward_A_E !== (FWD ? 2'b10 : 2'b00)) begin
            errors++; $display("FAIL fwdA_mem_prio: got %b expected %b", forward_A_E, FWD ? 2'b10 : 2'b00);
        end
        RD_M = 5'd0; #1;
        checks++;
        if (forward_A_E !== (FWD ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL fwdA_wb: got %b expected %b", forward_A_E, FWD ? 2'b01 : 2'b00);
        end
        RD_M = 5'd5; regwrite_en_M = 1'b0; Rs2_E = 5'd5; Rs1_E = 5'd6; #1;
        checks++;
        if (forward_B_E !== (FWD ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL fwdB_wb_noweM: got %b expected %b", forward_B_E, FWD ? 2'b01 : 2'b00);
        end
        checks++;
        if (forward_A_E !== 2'b00) begin
            errors++; $display("FAIL fwdA_nomatch: got %b expected 00", forward_A_E);
        end
        Rs2_E = 5'd0; RD_W = 5'd0; RD_M = 5'd0; regwrite_en_M = 1'b1; #1;
        checks++;
        if (forward_B_E !== 2'b00) begin
            errors++; $display("FAIL fwdB_x0: got %b expected 00", forward_B_E);
        end
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL fwd_no_stall: got %b expected %b", ctl, CTL_NONE);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load(5'd7); Rs2_D = 5'd7;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL lu_ctl: got %b expected %b", ctl, CTL_LU);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL lu_one_bubble: got %b expected %b", ctl, CTL_NONE);
        end
        checks++;
        if (stall_cycles !== 4'd1) begin
            errors++; $display("FAIL lu_stall_cycles: got %0d expected 1", stall_cycles);
        end
        set_load(5'd0); #1;
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL lu_x0: got %b expected %b", ctl, CTL_NONE);
        end
        clear_inputs();
        wb_src_E = 2'b00; regwrite_en_E = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7; #1;
        checks++;
        if (ctl !== (FWD ? CTL_NONE : CTL_LU)) begin
            errors++; $display("FAIL raw_alu_E: got %b expected %b", ctl, FWD ? CTL_NONE : CTL_LU);
        end
        clear_inputs();
        RD_W = 5'd3; regwrite_en_W = 1'b1; Rs1_D = 5'd3; #1;
        checks++;
        if (ctl !== (FWD ? CTL_NONE : CTL_LU)) begin
            errors++; $display("FAIL raw_W: got %b expected %b", ctl, FWD ? CTL_NONE : CTL_LU);
        end
        checks++;
        if (forward_A_E !== 2'b00) begin
            errors++; $display("FAIL raw_W_fwdA: got %b expected 00", forward_A_E);
        end
        clear_inputs();
    endtask

    task automatic test_branch_vs_lu();
        do_reset();
        set_load(5'd7); Rs2_D = 5'd7; pc_src_E = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_BR) begin
            errors++; $display("FAIL branch_wins: got %b expected %b", ctl, CTL_BR);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== 4'd0) begin
            errors++; $display("FAIL branch_stall_cycles: got %0d expected 0", stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req_M = 1'b1; pc_src_E = 1'b1; set_load(5'd7); Rs1_D = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== CTL_MW) begin
                errors++; $display("FAIL mw_ctl[%0d]: got %b expected %b", i, ctl, CTL_MW);
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_BR) begin
            errors++; $display("FAIL mw_release: got %b expected %b", ctl, CTL_BR);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== 4'd3) begin
            errors++; $display("FAIL mw_stall_cycles: got %0d expected 3", stall_cycles);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL mw_no_timeout: got %b expected 0", mem_timeout);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req_M = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_timeout !== (e >= 5)) begin
                errors++; $display("FAIL timeout_edge%0d: got %b expected %b", e, mem_timeout, e >= 5);
            end
        end
        dmem_req_M = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b expected 1", mem_timeout);
        end
        checks++;
        if (stall_cycles !== 4'd7) begin
            errors++; $display("FAIL timeout_stall_cycles: got %0d expected 7", stall_cycles);
        end
        dmem_req_M = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL rst_in_wait_ctl: got %b expected %b", ctl, CTL_NONE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_clears_timeout: got %b expected 0", mem_timeout);
        end
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_timeout !== (e >= 5)) begin
                errors++; $display("FAIL post_rst_edge%0d: got %b expected %b", e, mem_timeout, e >= 5);
            end
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        dmem_req_M = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk); #1;
            checks++;
            if (stall_cycles !== ((e > 15) ? 4'd15 : 4'(e))) begin
                errors++; $display("FAIL sat_edge%0d: got %0d expected %0d", e, stall_cycles, (e > 15) ? 15 : e);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_load(5'd7); Rs1_D = 5'd7;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL b2b_lu1: got %b expected %b", ctl, CTL_LU);
        end
        @(posedge clk); #1;
        RD_E = 5'd9; Rs1_D = 5'd0; Rs2_D = 5'd9;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_LU) begin
            errors++; $display("FAIL b2b_lu2: got %b expected %b", ctl, CTL_LU);
        end
        @(posedge clk); #1;
        clear_inputs(); pc_src_E = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_BR) begin
            errors++; $display("FAIL b2b_branch: got %b expected %b", ctl, CTL_BR);
        end
        @(posedge clk); #1;
        clear_inputs(); dmem_req_M = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_MW) begin
            errors++; $display("FAIL b2b_mw: got %b expected %b", ctl, CTL_MW);
        end
        @(posedge clk); #1;
        dmem_req_M = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_NONE) begin
            errors++; $display("FAIL b2b_req_drop: got %b expected %b", ctl, CTL_NONE);
        end
        checks++;
        if (stall_cycles !== 4'd3) begin
            errors++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stall_cycles);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_lu();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
